// File: rtl/output_drain_pkg.sv
// Shared types and defaults for the output feature-map drain FIFO.
//   state_t     : drain FSM states (IDLE, STREAM, FLUSH)
//   coord_t     : x/y/channel tag stored alongside each word
//   DEFAULT_*   : default DEPTH / DATA_WIDTH for output_drain_fifo
package output_drain_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned COORD_WIDTH        = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Coordinate tag; ch sits in the MSBs of a stored entry.
    typedef struct packed {
        logic [COORD_WIDTH-1:0] ch;
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] x;
    } coord_t;

    localparam int unsigned COORD_BITS = $bits(coord_t);

endpackage

// File: rtl/drain_fifo_mem.sv
// Register-array storage for the drain FIFO.
// Ports:
//   clk        : clock, write on rising edge
//   wr_en      : write enable
//   wr_ptr     : write address
//   wr_data    : entry to store
//   rd_ptr     : read address
//   rd_data_c  : combinational read of entry at rd_ptr
module drain_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [WIDTH-1:0]         rd_data_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entries are not reset; validity is tracked by the controller.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_ptr];

endmodule

// File: rtl/output_drain_fifo.sv
// Output feature-map drain FIFO with flush/drain control.
// Buffers tagged output words from the compute engine (which cannot be
// back-pressured, only held via almost_full) and presents them to the
// downstream writer with a registered head (latency 1, no fall-through).
// Ports:
//   clk, arst_n_in               : clock, synchronous active-low reset
//   in_valid/in_data/in_x/y/ch   : incoming word and coordinates
//   flush                        : drain FIFO and end the frame
//   out_valid/out_ready          : head handshake
//   out_data/out_x/y/ch          : registered head entry
//   almost_full                  : count >= AF_LEVEL
//   overflow                     : sticky, a word was dropped
//   count                        : registered occupancy
//   drain_done                   : one-cycle pulse when a flush completes
//   stat_words                   : accepted-word counter
// Build option: OUTPUT_DRAIN_STATS_EN enables the stat_words counter;
// otherwise stat_words is tied to zero.
module output_drain_fifo
    import output_drain_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned AF_LEVEL   = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         arst_n_in,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [31:0]                  in_x,
    input  logic [31:0]                  in_y,
    input  logic [31:0]                  in_ch,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [31:0]                  out_x,
    output logic [31:0]                  out_y,
    output logic [31:0]                  out_ch,
    output logic                         almost_full,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drain_done,
    output logic [31:0]                  stat_words
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_WIDTH + COORD_BITS;

    state_t             state_q;
    state_t             state_d;
    logic               drain_done_d;

    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_d;

    logic               accept_c;
    logic               full_c;
    logic               pop_c;
    logic               push_c;
    logic               drop_c;
    logic               fwd_c;

    coord_t             wr_coord_c;
    logic [ENTRY_W-1:0] wr_entry_c;
    logic [ENTRY_W-1:0] rd_entry_c;
    logic [ENTRY_W-1:0] head_d;
    coord_t             head_coord_c;

    // Storage array
    drain_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (push_c),
        .wr_ptr    (wr_ptr_q),
        .wr_data   (wr_entry_c),
        .rd_ptr    (rd_ptr_d),
        .rd_data_c (rd_entry_c)
    );

    // Push/pop qualification, next occupancy and next head entry
    always_comb begin
        accept_c   = (state_q != FLUSH);
        full_c     = (count == CNT_W'(DEPTH));
        pop_c      = out_valid && out_ready;
        push_c     = in_valid && accept_c && (!full_c || pop_c);
        drop_c     = in_valid && accept_c && full_c && !pop_c;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        count_d    = count + CNT_W'(push_c) - CNT_W'(pop_c);

        wr_coord_c    = '0;
        wr_coord_c.x  = in_x;
        wr_coord_c.y  = in_y;
        wr_coord_c.ch = in_ch;
        wr_entry_c    = {wr_coord_c, in_data};

        // The incoming word becomes the head only when the FIFO is (or is
        // about to become) empty; then it has not reached the array yet.
        fwd_c  = push_c && (wr_ptr_q == rd_ptr_d);
        head_d = fwd_c ? wr_entry_c : rd_entry_c;
        head_coord_c = coord_t'(head_d[ENTRY_W-1 -: COORD_BITS]);
    end

    // Pointers, occupancy, flags and registered head
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            out_data    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_ch      <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q    <= rd_ptr_d;
            count       <= count_d;
            out_valid   <= (count_d != '0);
            almost_full <= (32'(count_d) >= AF_LEVEL);
            if (drop_c) begin
                overflow <= 1'b1;
            end
            // Head only reloads when it changes; it holds while stalled.
            if (count_d != '0) begin
                out_data <= head_d[DATA_WIDTH-1:0];
                out_x    <= head_coord_c.x;
                out_y    <= head_coord_c.y;
                out_ch   <= head_coord_c.ch;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            drain_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_done <= drain_done_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (count == '0) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accepted-word statistics
`ifdef OUTPUT_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            stat_words <= '0;
        end else if (push_c) begin
            stat_words <= stat_words + 32'd1;
        end
    end
`else
    assign stat_words = '0;
`endif

endmodule

// File: tb/tb_output_drain_fifo.sv
// Self-checking bench for output_drain_fifo (DEPTH=8, DATA_WIDTH=32).
module tb_output_drain_fifo;
    import output_drain_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AF    = 6;
`ifdef OUTPUT_DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          arst_n_in;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [31:0]   in_x, in_y, in_ch;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_x, out_y, out_ch;
    logic          almost_full;
    logic          overflow;
    logic [3:0]    count;
    logic          drain_done;
    logic [31:0]   stat_words;

    int total = 0;
    int bad   = 0;

    output_drain_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF)) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .in_valid(in_valid), .in_data(in_data),
        .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
        .almost_full(almost_full), .overflow(overflow), .count(count),
        .drain_done(drain_done), .stat_words(stat_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] d;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } ent_t;

    ent_t mq[$];
    int   m_mode      = 0;   // 0 idle, 1 streaming, 2 flushing
    bit   m_ovf       = 0;
    bit   m_dd        = 0;
    int   m_stat      = 0;
    bit   m_zero_head = 1;
    bit   started     = 0;

    always @(posedge clk) begin
        bit pop, push, acc, full;
        ent_t e;
        started = 1;
        if (!arst_n_in) begin
            mq.delete();
            m_mode = 0; m_ovf = 0; m_dd = 0; m_stat = 0; m_zero_head = 1;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            acc  = (m_mode != 2);
            full = (mq.size() == DEPTH);
            push = in_valid && acc && (!full || pop);
            if (in_valid && acc && full && !pop) m_ovf = 1;
            m_dd = 0;
            case (m_mode)
                0: if (flush) m_mode = 2; else if (in_valid) m_mode = 1;
                1: if (flush) m_mode = 2;
                default: if (mq.size() == 0) begin m_mode = 0; m_dd = 1; end
            endcase
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.d = in_data; e.x = in_x; e.y = in_y; e.ch = in_ch;
                mq.push_back(e);
                m_stat++;
                m_zero_head = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("out_valid",   64'(out_valid),   64'(mq.size() != 0));
            check("count",       64'(count),       64'(mq.size()));
            check("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
            check("overflow",    64'(overflow),    64'(m_ovf));
            check("drain_done",  64'(drain_done),  64'(m_dd));
            check("stat_words",  64'(stat_words),  STATS ? 64'(m_stat) : 64'd0);
            if (mq.size() != 0) begin
                check("head_data", 64'(out_data), 64'(mq[0].d));
                check("head_x",    64'(out_x),    64'(mq[0].x));
                check("head_y",    64'(out_y),    64'(mq[0].y));
                check("head_ch",   64'(out_ch),   64'(mq[0].ch));
            end else if (m_zero_head) begin
                check("reset_data", 64'(out_data), 64'd0);
                check("reset_x",    64'(out_x),    64'd0);
                check("reset_y",    64'(out_y),    64'd0);
                check("reset_ch",   64'(out_ch),   64'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] ch);
        in_valid = 1'b1; in_data = d; in_x = x; in_y = y; in_ch = ch;
    endtask

    task automatic reset_dut();
        arst_n_in = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick();
        arst_n_in = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got[$];
        int dd_pulses;

        arst_n_in = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
        tick(); tick();
        arst_n_in = 1'b1;
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_state",     64'(dut.state_q), 64'(IDLE));

        // Basic push and latency
        drive_word(32'h11, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_data",  64'(out_data),  64'h11);
        check("t1_count",     64'(count),     64'd1);
        check("t1_state",     64'(dut.state_q), 64'(STREAM));

        // Fill and overflow
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            drive_word(i, i, i + 100, i + 200);
            tick();
            if (i == 4) check("t2_af_at5", 64'(almost_full), 64'd0);
            if (i == 5) check("t2_af_at6", 64'(almost_full), 64'd1);
        end
        in_valid = 1'b0;
        check("t2_count",    64'(count),    64'd8);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_head",     64'(out_data), 64'd0);
        check("t2_head_y",   64'(out_y),    64'd100);

        // Full with simultaneous push and pop
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            drive_word(i, i + 10, i + 20, i + 30);
            tick();
        end
        drive_word(8, 18, 28, 38);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_count",    64'(count),    64'd8);
        check("t3_overflow", 64'(overflow), 64'd0);
        for (int k = 0; k < 8; k++) begin
            check("t3_order", 64'(out_data), 64'(k + 1));
            tick();
        end
        check("t3_empty", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Pointer wrap with toggling out_ready
        reset_dut();
        got.delete();
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) drive_word(c / 2, c, c, c);
            else in_valid = 1'b0;
            out_ready = (c % 2 == 0);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        out_ready = 1'b0;
        check("t4_n_words", 64'(got.size()), 64'd20);
        for (int k = 0; k < 20; k++) begin
            if (k < got.size()) check("t4_order", 64'(got[k]), 64'(k));
        end
        check("t4_overflow", 64'(overflow), 64'd0);

        // Flush with input during FLUSH
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive_word(32'h30 + i, i, i, i);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_state_flush", 64'(dut.state_q), 64'(FLUSH));
        drive_word(32'hDEAD, 1, 2, 3);
        tick();
        tick();
        check("t5_count0",   64'(count),      64'd0);
        check("t5_dd_early", 64'(drain_done), 64'd0);
        tick();
        in_valid = 1'b0;
        check("t5_dd",       64'(drain_done),    64'd1);
        check("t5_state",    64'(dut.state_q),   64'(IDLE));
        check("t5_overflow", 64'(overflow),      64'd0);
        check("t5_dropped",  64'(count),         64'd0);
        dd_pulses = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (drain_done) dd_pulses++;
        end
        check("t5_pulses", 64'(dd_pulses), 64'd1);
        out_ready = 1'b0;

        // Reset mid-stream and statistics
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            drive_word(32'h50 + i, i, i, i);
            tick();
        end
        in_valid = 1'b0;
        arst_n_in = 1'b0;
        tick();
        arst_n_in = 1'b1;
        check("t6_count",    64'(count),      64'd0);
        check("t6_valid",    64'(out_valid),  64'd0);
        check("t6_overflow", 64'(overflow),   64'd0);
        check("t6_data",     64'(out_data),   64'd0);
        check("t6_stat0",    64'(stat_words), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive_word(32'h60 + i, i, i, i);
            tick();
        end
        in_valid = 1'b0;
        check("t6_stat4", 64'(stat_words), STATS ? 64'd4 : 64'd0);
        check("t6_count4", 64'(count), 64'd4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
